heading_painter: RTL and testbench

- Write-side counterpart of the heading sprite display path: owns a WIDTH x HEIGHT buffer of 4-bit colour indices and draws into it from pixel-plot and rectangle-fill commands.
- Serves the VGA scan path through the same hc/vc / is_in_pixel read interface as the existing display blocks: 8x8 screen pixels per cell, colour 8 = transparent.
- Sits between game logic (command producer) and the pixel mux.

---
 rtl/heading_painter.sv | 125 ++++++++++++
 tb/tb_heading_painter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/heading_painter.sv
// heading_painter: WIDTH x HEIGHT colour-index buffer drawn by plot/fill commands, read by the VGA scan path.
module heading_painter #(
  parameter int WIDTH = 53,
  parameter int HEIGHT = 12,
  parameter logic [3:0] TRANSPARENT = 4'd8,
  parameter int XW = 6,
  parameter int YW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [XW-1:0] cmd_x,
  input  logic [YW-1:0] cmd_y,
  input  logic [XW-1:0] cmd_w,
  input  logic [YW-1:0] cmd_h,
  input  logic [3:0]    cmd_color,
  output logic          busy,
  output logic          done,
  input  logic          is_in_pixel,
  input  logic [9:0]    hc,
  input  logic [9:0]    vc,
  output logic [3:0]    pixel
);
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam logic [9:0] DEPTH_A = 10'(DEPTH);
  localparam logic [9:0] LAST_A = 10'(DEPTH - 1);
  typedef enum logic [1:0] {CLEAR, IDLE, DRAW} state_t;
  state_t state, state_n;
  logic [3:0] mem [DEPTH];
  logic [9:0] clr_addr, wa, ra;
  logic we, accept, active, empty, last_x, last_y, rd_sel, unused_lsb;
  logic [3:0] wd, col, rd_q;
  logic [XW-1:0] x0, cx, w_eff;
  logic [YW-1:0] cy, h_eff;
  logic [XW:0] xe, x_sum;
  logic [YW:0] ye, y_sum;
  assign unused_lsb = ^{hc[2:0], vc[2:0]};
  assign w_eff = cmd_op ? cmd_w : XW'(1);
  assign h_eff = cmd_op ? cmd_h : YW'(1);
  assign x_sum = {1'b0, cmd_x} + {1'b0, w_eff};
  assign y_sum = {1'b0, cmd_y} + {1'b0, h_eff};
  assign empty = ({1'b0, cmd_x} >= (XW+1)'(WIDTH)) || ({1'b0, cmd_y} >= (YW+1)'(HEIGHT)) ||
                 (w_eff == '0) || (h_eff == '0);
  assign last_x = ({1'b0, cx} + (XW+1)'(1)) == xe;
  assign last_y = ({1'b0, cy} + (YW+1)'(1)) == ye;
  assign accept = cmd_valid && cmd_ready;
  always_comb begin
    state_n = state;
    cmd_ready = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    we = 1'b0;
    wa = clr_addr;
    wd = TRANSPARENT;
    case (state)
      CLEAR: begin
        we = 1'b1;
        state_n = clr_addr == LAST_A ? IDLE : CLEAR;
      end
      IDLE: begin
        cmd_ready = 1'b1;
        busy = 1'b0;
        state_n = cmd_valid ? DRAW : IDLE;
      end
      DRAW: begin
        if (active) begin
          we = 1'b1;
          wa = 10'(cy) * 10'(WIDTH) + 10'(cx);
          wd = col;
        end else begin
          done = 1'b1;
          cmd_ready = 1'b1;
          busy = 1'b0;
          state_n = cmd_valid ? DRAW : IDLE;
        end
      end
      default: state_n = CLEAR;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_n;
      clr_addr <= state == CLEAR ? clr_addr + 10'd1 : '0;
    end
  end
  // Clipped bounds are fixed at acceptance; an empty region simply never goes active.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active <= 1'b0;
      x0 <= '0;
      cx <= '0;
      cy <= '0;
      xe <= '0;
      ye <= '0;
      col <= '0;
    end else if (accept) begin
      active <= !empty;
      x0 <= cmd_x;
      cx <= cmd_x;
      cy <= cmd_y;
      xe <= x_sum > (XW+1)'(WIDTH) ? (XW+1)'(WIDTH) : x_sum;
      ye <= y_sum > (YW+1)'(HEIGHT) ? (YW+1)'(HEIGHT) : y_sum;
      col <= cmd_color;
    end else if (state == DRAW && active) begin
      cx <= last_x ? x0 : cx + XW'(1);
      cy <= last_x && !last_y ? cy + YW'(1) : cy;
      active <= !(last_x && last_y);
    end
  end
  assign ra = 10'(hc[9:3]) + 10'(vc[9:3]) * 10'(WIDTH);
  always_ff @(posedge CLK) begin
    if (we) mem[wa] <= wd;
    rd_q <= mem[ra < DEPTH_A ? ra : '0];
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rd_sel <= 1'b0;
    else rd_sel <= is_in_pixel && (ra < DEPTH_A);
  end
  assign pixel = rd_sel ? rd_q : TRANSPARENT;
endmodule

// File: tb/tb_heading_painter.sv
// tb_heading_painter: directed checks of clear, plot, clipped fill, empty commands, read gating and reset abort.
module tb_heading_painter;
  localparam int W = 53, H = 12, D = W * H;
  logic CLK = 0, RST = 1, cmd_valid = 0, cmd_op = 0, is_in_pixel = 0;
  logic [5:0] cmd_x = 0, cmd_w = 0;
  logic [3:0] cmd_y = 0, cmd_h = 0, cmd_color = 0;
  logic [9:0] hc = 0, vc = 0;
  logic cmd_ready, busy, done;
  logic [3:0] pixel;
  logic [3:0] model [D];
  logic [3:0] sb [$];
  int checks = 0, failures = 0;

  heading_painter dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .busy(busy), .done(done), .is_in_pixel(is_in_pixel), .hc(hc), .vc(vc), .pixel(pixel)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge CLK);
    end
    chk({tag, "_busy_cycles"}, n, 636);
    chk({tag, "_ready"}, cmd_ready, 1);
    for (int i = 0; i < D; i++) model[i] = 4'd8;
  endtask

  task automatic rd(input string tag, input int h, input int v, input logic en);
    int idx;
    hc = 10'(h);
    vc = 10'(v);
    is_in_pixel = en;
    idx = ((h / 8) + (v / 8) * W) % 1024;
    sb.push_back((!en || idx >= D) ? 4'd8 : model[idx]);
    @(negedge CLK);
    chk(tag, pixel, sb.pop_front());
  endtask

  task automatic scan_all(input string tag);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) rd(tag, x * 8 + (x % 8), y * 8 + ((x + y) % 8), 1'b1);
  endtask

  task automatic cmd(input string tag, input int op, input int x, input int y, input int w, input int h, input int c);
    int we_, he_, cells, n;
    cells = 0;
    n = 1;
    we_ = op != 0 ? w : 1;
    he_ = op != 0 ? h : 1;
    for (int yy = y; yy < y + he_ && yy < H; yy++)
      for (int xx = x; xx < x + we_ && xx < W; xx++) begin
        model[yy * W + xx] = 4'(c);
        cells++;
      end
    chk({tag, "_ready"}, cmd_ready, 1);
    cmd_op = op[0];
    cmd_x = 6'(x);
    cmd_y = 4'(y);
    cmd_w = 6'(w);
    cmd_h = 4'(h);
    cmd_color = 4'(c);
    cmd_valid = 1;
    @(negedge CLK);
    cmd_valid = 0;
    chk({tag, "_busy"}, busy, cells > 0 ? 1 : 0);
    while (done !== 1'b1 && n < 4000) begin
      n++;
      @(negedge CLK);
    end
    chk({tag, "_latency"}, n, cells + 1);
    chk({tag, "_ready_at_done"}, cmd_ready, 1);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_pixel", pixel, 8);
    RST = 0;
    wait_clear("clear");
    scan_all("clear_scan");

    cmd("plot", 0, 3, 2, 0, 0, 5);
    for (int v = 16; v < 24; v++)
      for (int h = 24; h < 32; h++) rd("plot_px", h, v, 1'b1);
    rd("plot_right", 32, 16, 1'b1);

    cmd("clip", 1, 50, 10, 10, 5, 3);
    for (int y = 9; y < 12; y++)
      for (int x = 49; x < 53; x++) rd("clip_px", x * 8, y * 8, 1'b1);

    cmd("empty_w0", 1, 10, 5, 0, 3, 7);
    cmd("empty_x60", 1, 60, 1, 2, 2, 7);
    rd("empty_cell", 80, 40, 1'b1);
    rd("empty_row", 0, 8, 1'b1);
    rd("empty_edge", 52 * 8, 8, 1'b1);

    rd("gate_off", 24, 16, 1'b0);
    rd("gate_on", 24, 16, 1'b1);
    rd("oob", 0, 96, 1'b1);

    cmd("plot_ignores_wh", 0, 7, 7, 5, 3, 9);
    rd("plot_wh_cell", 56, 56, 1'b1);
    rd("plot_wh_next", 64, 56, 1'b1);

    is_in_pixel = 0;
    chk("mid_ready", cmd_ready, 1);
    cmd_op = 1;
    cmd_x = 0;
    cmd_y = 0;
    cmd_w = 53;
    cmd_h = 12;
    cmd_color = 2;
    cmd_valid = 1;
    @(negedge CLK);
    cmd_valid = 0;
    for (int i = 0; i < 100; i++) begin
      chk("mid_no_done", done, 0);
      @(negedge CLK);
    end
    RST = 1;
    #1;
    chk("abort_ready", cmd_ready, 0);
    chk("abort_busy", busy, 1);
    chk("abort_done", done, 0);
    chk("abort_pixel", pixel, 8);
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
    wait_clear("reclear");
    scan_all("reclear_scan");

    cmd("post_plot", 0, 52, 11, 0, 0, 1);
    rd("post_px", 52 * 8 + 7, 11 * 8 + 7, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
